// File: rtl/uart_tx_mmio_pkg.sv
// uart_tx_mmio_pkg: register offsets, STATUS bit positions, serializer states
package uart_tx_mmio_pkg;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF = 7;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;
  function automatic logic [7:0] status_byte(input logic busy, input logic full, input logic empty, input logic ovf);
    logic [7:0] s;
    s = '0;
    s[ST_BUSY] = busy;
    s[ST_FULL] = full;
    s[ST_EMPTY] = empty;
    s[ST_OVF] = ovf;
    return s;
  endfunction
endpackage

// File: rtl/uart_tx_mmio_byte_fifo.sv
// byte_fifo: first-word-fall-through byte FIFO; push/pop/din in, dout/full/empty/count out
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;
  logic w_pop, w_push;
  assign full = r_count == (AW+1)'(DEPTH);
  assign empty = r_count == '0;
  assign count = r_count;
  assign dout = r_mem[r_rptr];
  assign w_pop = pop && !empty;
  // a full FIFO still takes a push when the same cycle frees a slot
  assign w_push = push && (!full || w_pop);
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: CPU-bus mapped 8N1 UART transmitter with FIFO and drain IRQ
//   in : clk, reset, addr[15:0], wdata[7:0], rw (1=read), phi2
//   out: rdata[7:0], rsel, txd (idle high), irq
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0200,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        rw,
  input  logic        phi2,
  output logic [7:0]  rdata,
  output logic        rsel,
  output logic        txd,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic r_phi2_d, r_ovf, r_irq_en, r_irq, r_txd, r_rsel;
  logic [7:0] r_rdata, r_shift;
  logic [15:0] r_cnt;
  logic [2:0] r_bit;
  tx_state_t r_state;
  logic w_hit, w_stb, w_wr_data, w_wr_status, w_wr_ctrl;
  logic w_last, w_busy, w_pop, w_full, w_empty, w_ovf_set;
  logic [7:0] w_dout, w_rd_val;
  logic [CW-1:0] w_count;
  assign w_hit = addr[15:2] == BASE_ADDR[15:2];
  // one strobe per store: first clk of each phi2 high phase
  assign w_stb = phi2 && !r_phi2_d && !rw && w_hit;
  assign w_wr_data = w_stb && addr[1:0] == REG_DATA;
  assign w_wr_status = w_stb && addr[1:0] == REG_STATUS;
  assign w_wr_ctrl = w_stb && addr[1:0] == REG_CTRL;
  assign w_last = r_cnt == 16'(CLKS_PER_BIT - 1);
  assign w_busy = r_state != S_IDLE;
  assign w_pop = !w_empty && (r_state == S_IDLE || (r_state == S_STOP && w_last));
  assign w_ovf_set = w_wr_data && w_count == CW'(FIFO_DEPTH) && !w_pop;
  assign w_rd_val = addr[1:0] == REG_STATUS ? status_byte(w_busy, w_full, w_empty, r_ovf) :
                    addr[1:0] == REG_CTRL ? {7'b0, r_irq_en} : 8'h00;
  assign rdata = r_rdata;
  assign rsel = r_rsel;
  assign txd = r_txd;
  assign irq = r_irq;
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(w_wr_data),
    .pop(w_pop),
    .din(wdata),
    .dout(w_dout),
    .full(w_full),
    .empty(w_empty),
    .count(w_count)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phi2_d <= 1'b0;
      r_ovf <= 1'b0;
      r_irq_en <= 1'b0;
      r_irq <= 1'b0;
      r_rdata <= '0;
      r_rsel <= 1'b0;
    end else begin
      r_phi2_d <= phi2;
      r_ovf <= w_ovf_set || (r_ovf && !(w_wr_status && wdata[7]));
      if (w_wr_ctrl) r_irq_en <= wdata[0];
      r_irq <= r_irq_en && w_empty && !w_busy;
      r_rdata <= (w_hit && rw) ? w_rd_val : 8'h00;
      r_rsel <= w_hit && rw;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_txd <= 1'b1;
      r_cnt <= '0;
      r_bit <= '0;
      r_shift <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift <= w_dout;
            r_state <= S_START;
            r_txd <= 1'b0;
            r_cnt <= '0;
          end
        end
        S_START: begin
          if (w_last) begin
            r_cnt <= '0;
            r_bit <= '0;
            r_state <= S_DATA;
            r_txd <= r_shift[0];
          end else r_cnt <= r_cnt + 16'd1;
        end
        S_DATA: begin
          if (w_last) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_txd <= 1'b1;
            end else begin
              r_bit <= r_bit + 3'd1;
              r_shift <= r_shift >> 1;
              r_txd <= r_shift[1];
            end
          end else r_cnt <= r_cnt + 16'd1;
        end
        S_STOP: begin
          if (w_last) begin
            r_cnt <= '0;
            if (w_pop) begin
              r_shift <= w_dout;
              r_state <= S_START;
              r_txd <= 1'b0;
            end else r_state <= S_IDLE;
          end else r_cnt <= r_cnt + 16'd1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed self-checking bench for uart_tx_mmio
module tb_uart_tx_mmio;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rw = 1'b1;
  logic phi2 = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic rsel, txd, irq;
  int checks = 0;
  int failures = 0;
  logic [7:0] rx_q[$];
  always #5 clk = ~clk;
  uart_tx_mmio #(.BASE_ADDR(16'h0200), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .wdata(wdata),
    .rw(rw),
    .phi2(phi2),
    .rdata(rdata),
    .rsel(rsel),
    .txd(txd),
    .irq(irq)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    tick;
    addr = a;
    wdata = d;
    rw = 1'b0;
    phi2 = 1'b0;
    tick;
    phi2 = 1'b1;
    tick;
    phi2 = 1'b0;
    rw = 1'b1;
    addr = 16'h0000;
  endtask
  task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp, input logic exp_sel);
    tick;
    addr = a;
    rw = 1'b1;
    tick;
    check({tag, "_rdata"}, 32'(rdata), 32'(exp));
    check({tag, "_rsel"}, 32'(rsel), 32'(exp_sel));
    addr = 16'h0000;
  endtask
  initial begin
    logic [7:0] b;
    forever begin
      @(posedge clk);
      #2;
      if (!reset && txd === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (i == 0 ? 6 : 4) @(posedge clk);
          #2;
          b[i] = txd;
        end
        repeat (4) @(posedge clk);
        rx_q.push_back(b);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] v;
    logic e;
    int lows;
    repeat (3) tick;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rsel", 32'(rsel), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    reset = 1'b0;
    tick;
    v = 8'hA5;
    wr(16'h0200, v);
    check("a5_txd_0", 32'(txd), 32'd1);
    for (int j = 1; j <= 41; j++) begin
      tick;
      e = j <= 4 ? 1'b0 : j <= 36 ? v[(j-5)/4] : 1'b1;
      check($sformatf("a5_txd_%0d", j), 32'(txd), 32'(e));
    end
    rd("a5_status", 16'h0201, 8'h04, 1'b1);
    check("a5_rx_count", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) check("a5_rx_byte", 32'(rx_q[0]), 32'hA5);
    rx_q.delete();
    for (int i = 0; i < 5; i++) wr(16'h0200, 8'(8'h11 * (i + 1)));
    rd("five_status", 16'h0201, 8'h03, 1'b1);
    for (int i = 0; i < 6; i++) wr(16'h0200, 8'(8'h60 + i));
    rd("ovf_status", 16'h0201, 8'h83, 1'b1);
    repeat (240) tick;
    check("five_rx_count", rx_q.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < rx_q.size()) check($sformatf("five_rx_%0d", i), 32'(rx_q[i]), 32'(8'h11 * (i + 1)));
    rd("drained_status", 16'h0201, 8'h84, 1'b1);
    wr(16'h0201, 8'h80);
    rd("ovf_clr_status", 16'h0201, 8'h04, 1'b1);
    rx_q.delete();
    check("irq_off", 32'(irq), 32'd0);
    wr(16'h0202, 8'h01);
    tick;
    check("irq_on", 32'(irq), 32'd1);
    rd("ctrl_rd", 16'h0202, 8'h01, 1'b1);
    wr(16'h0200, 8'h81);
    check("irq_push_cycle", 32'(irq), 32'd1);
    tick;
    check("irq_dropped", 32'(irq), 32'd0);
    repeat (40) tick;
    check("irq_before_idle", 32'(irq), 32'd0);
    tick;
    check("irq_back", 32'(irq), 32'd1);
    check("irq_rx_count", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) check("irq_rx_byte", 32'(rx_q[0]), 32'h81);
    rx_q.delete();
    addr = 16'h0200;
    wdata = 8'h99;
    rw = 1'b0;
    phi2 = 1'b0;
    repeat (10) tick;
    rw = 1'b1;
    addr = 16'h0000;
    rd("lowphi2_status", 16'h0201, 8'h04, 1'b1);
    tick;
    addr = 16'h0200;
    wdata = 8'h3C;
    rw = 1'b0;
    tick;
    phi2 = 1'b1;
    repeat (5) tick;
    phi2 = 1'b0;
    rw = 1'b1;
    addr = 16'h0000;
    repeat (85) tick;
    check("long_phi2_rx_count", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) check("long_phi2_rx_byte", 32'(rx_q[0]), 32'h3C);
    rd("long_phi2_status", 16'h0201, 8'h04, 1'b1);
    rx_q.delete();
    wr(16'h0200, 8'hF0);
    repeat (18) tick;
    check("pre_reset_bit3", 32'(txd), 32'd0);
    reset = 1'b1;
    tick;
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    rd("reset_status", 16'h0201, 8'h04, 1'b1);
    rd("reset_ctrl", 16'h0202, 8'h00, 1'b1);
    lows = 0;
    repeat (60) begin
      tick;
      if (txd !== 1'b1) lows++;
    end
    check("reset_no_tx", 32'(lows), 32'd0);
    rd("rd_status", 16'h0201, 8'h04, 1'b1);
    rd("rd_outside", 16'h0280, 8'h00, 1'b0);
    rd("rd_reserved", 16'h0203, 8'h00, 1'b1);
    rd("rd_data", 16'h0200, 8'h00, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
